activation_mem_ctrl: RTL and testbench



---
 rtl/activation_mem_ctrl_pkg.sv | 22 ++
 rtl/activation_mem_ctrl_if.sv | 38 +++
 rtl/activation_mem_ctrl.sv | 105 ++++++++++
 tb/tb_activation_mem_ctrl.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/activation_mem_ctrl_pkg.sv
// Shared accelerator definitions: tile geometry, derived address widths and controller state encoding.
// Parameters default from here so the interface and controller agree on widths.
package activation_mem_ctrl_pkg;

   localparam int ACT_SIZE     = 8;
   localparam int ACT_MEM_SIZE = ACT_SIZE * ACT_SIZE;
   localparam int ACT_WR_AW    = $clog2(ACT_MEM_SIZE);
   localparam int ACT_RD_AW    = $clog2(ACT_SIZE);
   localparam int ACT_DW       = 7;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOAD   = 2'd1,
      LOADED = 2'd2,
      READ   = 2'd3
   } state_t;

   function automatic logic state_is_busy(state_t s);
      return (s == LOAD) || (s == READ);
   endfunction

endpackage

// File: rtl/activation_mem_ctrl_if.sv
// Controller-side bus: upstream activation handshake, array read control and memory port signals.
// master drives requests and activation words; slave is the controller.
interface activation_mem_ctrl_if
   import activation_mem_ctrl_pkg::*;
#(
   parameter int WRITE_ADDR_WIDTH = ACT_WR_AW,
   parameter int READ_ADDR_WIDTH  = ACT_RD_AW
);

   logic                        load_start;
   logic                        act_valid;
   logic [ACT_DW-1:0]           act_data;
   logic                        act_ready;
   logic                        rd_go;
   logic                        rd_hold;
   logic                        Wr_en;
   logic [WRITE_ADDR_WIDTH-1:0] Wr_Addr;
   logic [ACT_DW-1:0]           Activation;
   logic                        Rd_en;
   logic [READ_ADDR_WIDTH-1:0]  Rd_Addr;
   logic                        act_out_valid;
   logic                        loaded;
   logic                        busy;
   logic                        done;

   modport master (
      output load_start, act_valid, act_data, rd_go, rd_hold,
      input  act_ready, Wr_en, Wr_Addr, Activation, Rd_en, Rd_Addr,
             act_out_valid, loaded, busy, done
   );

   modport slave (
      input  load_start, act_valid, act_data, rd_go, rd_hold,
      output act_ready, Wr_en, Wr_Addr, Activation, Rd_en, Rd_Addr,
             act_out_valid, loaded, busy, done
   );

endinterface

// File: rtl/activation_mem_ctrl.sv
// Activation tile controller: writes SIZE*SIZE words into memory, then streams SIZE columns on demand.
// Writes pass through combinationally; act_out_valid/done lag Rd_en by one cycle; rd_hold freezes reads.
module activation_mem_ctrl
   import activation_mem_ctrl_pkg::*;
#(
   parameter int SIZE             = ACT_SIZE,
   parameter int MEM_SIZE         = SIZE * SIZE,
   parameter int WRITE_ADDR_WIDTH = $clog2(MEM_SIZE),
   parameter int READ_ADDR_WIDTH  = $clog2(SIZE)
) (
   input  logic                clk,
   input  logic                rst,
   activation_mem_ctrl_if.slave bus
);

   state_t                      state_q, state_d;
   logic [WRITE_ADDR_WIDTH-1:0] wr_cnt_q, wr_cnt_d;
   logic [READ_ADDR_WIDTH-1:0]  rd_cnt_q, rd_cnt_d;
   logic                        loaded_q, loaded_d;
   logic                        out_vld_q, out_vld_d;
   logic                        done_q, done_d;

   logic wr_fire, rd_fire, wr_last, rd_last;

   assign wr_fire = (state_q == LOAD) && bus.act_valid;
   assign rd_fire = (state_q == READ) && !bus.rd_hold;
   assign wr_last = (wr_cnt_q == WRITE_ADDR_WIDTH'(MEM_SIZE - 1));
   assign rd_last = (rd_cnt_q == READ_ADDR_WIDTH'(SIZE - 1));

   always_comb begin
      state_d   = state_q;
      wr_cnt_d  = wr_cnt_q;
      rd_cnt_d  = rd_cnt_q;
      loaded_d  = loaded_q;
      // Memory registers its read output, so the column appears one cycle after Rd_en.
      out_vld_d = rd_fire;
      done_d    = rd_fire && rd_last;

      case (state_q)
         IDLE, LOADED: begin
            if (bus.load_start) begin
               state_d  = LOAD;
               wr_cnt_d = '0;
               loaded_d = 1'b0;
            end else if ((state_q == LOADED) && bus.rd_go) begin
               state_d  = READ;
               rd_cnt_d = '0;
            end
         end
         LOAD: begin
            if (wr_fire) begin
               if (wr_last) begin
                  state_d  = LOADED;
                  wr_cnt_d = '0;
                  loaded_d = 1'b1;
               end else begin
                  wr_cnt_d = wr_cnt_q + 1'b1;
               end
            end
         end
         READ: begin
            if (rd_fire) begin
               if (rd_last) begin
                  state_d  = LOADED;
                  rd_cnt_d = '0;
               end else begin
                  rd_cnt_d = rd_cnt_q + 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         wr_cnt_q  <= '0;
         rd_cnt_q  <= '0;
         loaded_q  <= 1'b0;
         out_vld_q <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         wr_cnt_q  <= wr_cnt_d;
         rd_cnt_q  <= rd_cnt_d;
         loaded_q  <= loaded_d;
         out_vld_q <= out_vld_d;
         done_q    <= done_d;
      end
   end

   // Address/data are zeroed when idle so the memory port is quiet outside transfers.
   assign bus.act_ready     = (state_q == LOAD);
   assign bus.Wr_en         = wr_fire;
   assign bus.Wr_Addr       = wr_fire ? wr_cnt_q : '0;
   assign bus.Activation    = wr_fire ? bus.act_data : '0;
   assign bus.Rd_en         = rd_fire;
   assign bus.Rd_Addr       = rd_fire ? rd_cnt_q : '0;
   assign bus.act_out_valid = out_vld_q;
   assign bus.loaded        = loaded_q;
   assign bus.busy          = state_is_busy(state_q);
   assign bus.done          = done_q;

endmodule

// File: tb/tb_activation_mem_ctrl.sv
// Bench for activation_mem_ctrl: directed load/read scenarios plus random traffic against a tile-level model.
module tb_activation_mem_ctrl;
   import activation_mem_ctrl_pkg::*;

   localparam int SIZE = 8;
   localparam int MEM  = SIZE * SIZE;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   activation_mem_ctrl_if bus ();

   activation_mem_ctrl #(.SIZE(SIZE)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   int errors = 0;
   int checks = 0;

   // Model: a tile is either being filled, being streamed, or resting; nothing else matters.
   bit   m_filling, m_streaming, m_have_tile, m_prev_rd, m_prev_last;
   int   m_words, m_cols;
   logic [6:0] gold [MEM];
   logic [6:0] mem  [MEM];

   always @(posedge clk) if (bus.Wr_en) mem[bus.Wr_Addr] <= bus.Activation;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_filling = 0; m_streaming = 0; m_have_tile = 0;
      m_prev_rd = 0; m_prev_last = 0; m_words = 0; m_cols = 0;
   endtask

   task automatic check_outputs();
      bit e_wr, e_rd;
      e_wr = m_filling && bus.act_valid;
      e_rd = m_streaming && !bus.rd_hold;
      chk("act_ready",  bus.act_ready, m_filling);
      chk("wr_en",      bus.Wr_en, e_wr);
      chk("wr_addr",    bus.Wr_Addr, e_wr ? m_words : 0);
      chk("activation", bus.Activation, e_wr ? bus.act_data : 7'd0);
      chk("rd_en",      bus.Rd_en, e_rd);
      chk("rd_addr",    bus.Rd_Addr, e_rd ? m_cols : 0);
      chk("out_valid",  bus.act_out_valid, m_prev_rd);
      chk("done",       bus.done, m_prev_last);
      chk("loaded",     bus.loaded, m_have_tile);
      chk("busy",       bus.busy, m_filling || m_streaming);
      chk("wr_rd_excl", bus.Wr_en & bus.Rd_en, 0);
   endtask

   task automatic model_step();
      bit e_wr, e_rd;
      e_wr = m_filling && bus.act_valid;
      e_rd = m_streaming && !bus.rd_hold;
      m_prev_rd   = e_rd;
      m_prev_last = e_rd && (m_cols == SIZE - 1);
      if (m_filling) begin
         if (e_wr) begin
            gold[m_words] = bus.act_data;
            m_words++;
            if (m_words == MEM) begin
               m_filling = 0; m_have_tile = 1; m_words = 0;
            end
         end
      end else if (m_streaming) begin
         if (e_rd) begin
            m_cols++;
            if (m_cols == SIZE) begin
               m_streaming = 0; m_cols = 0;
            end
         end
      end else if (bus.load_start) begin
         m_filling = 1; m_words = 0; m_have_tile = 0;
      end else if (bus.rd_go && m_have_tile) begin
         m_streaming = 1; m_cols = 0;
      end
   endtask

   task automatic cyc(input bit ls, input bit av, input logic [6:0] ad, input bit rg, input bit rh);
      bus.load_start = ls;
      bus.act_valid  = av;
      bus.act_data   = ad;
      bus.rd_go      = rg;
      bus.rd_hold    = rh;
      @(negedge clk);
      check_outputs();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_mem();
      for (int i = 0; i < MEM; i++) chk("mem_word", mem[i], gold[i]);
   endtask

   task automatic full_load();
      cyc(1, 0, 0, 0, 0);
      for (int i = 0; i < MEM; i++) cyc(0, 1, 7'($urandom), 0, 0);
   endtask

   initial begin
      rst = 1'b1;
      bus.load_start = 0; bus.act_valid = 0; bus.act_data = 0;
      bus.rd_go = 0; bus.rd_hold = 0;
      model_reset();
      for (int i = 0; i < MEM; i++) mem[i] = 'x;
      @(negedge clk);
      check_outputs();
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Back-to-back load of 0..63, then quiet cycles with act_ready low.
      cyc(1, 0, 0, 0, 0);
      for (int i = 0; i < MEM; i++) cyc(0, 1, 7'(i), 0, 0);
      chk("loaded_after_load", bus.loaded, 1);
      repeat (3) cyc(0, 1, 7'h55, 0, 0);
      check_mem();

      // Unheld read pass, then a pass with a 3-cycle hold after column 3.
      cyc(0, 0, 0, 1, 0);
      repeat (11) cyc(0, 0, 0, 0, 0);
      cyc(0, 0, 0, 1, 0);
      repeat (4) cyc(0, 0, 0, 0, 0);
      repeat (3) cyc(0, 0, 0, 0, 1);
      repeat (8) cyc(0, 0, 0, 0, 0);

      // load_start beats rd_go; gapped load with stray rd_go/load_start ignored.
      cyc(1, 0, 0, 1, 0);
      for (int k = 0, n = 0; n < MEM; k++) begin
         bit av;
         av = (k % 3) != 2;
         cyc(($urandom_range(0, 3) == 0), av, 7'($urandom), ($urandom_range(0, 2) == 0), 0);
         if (av) n++;
      end
      cyc(0, 0, 0, 0, 0);
      check_mem();

      // Reset in the middle of a load: everything drops at once and the old tile is gone.
      cyc(1, 0, 0, 0, 0);
      for (int i = 0; i < 30; i++) cyc(0, 1, 7'($urandom), 0, 0);
      bus.act_valid = 1; bus.act_data = 7'h7f; bus.rd_go = 1;
      rst = 1'b1;
      #1;
      model_reset();
      check_outputs();
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      repeat (3) cyc(0, 0, 0, 1, 0);
      full_load();
      cyc(0, 0, 0, 0, 0);
      check_mem();
      cyc(0, 0, 0, 1, 0);
      repeat (10) cyc(0, 0, 0, 0, 0);

      // Random traffic.
      repeat (3000) begin
         cyc(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0), 7'($urandom),
             ($urandom_range(0, 5) == 0), ($urandom_range(0, 3) == 0));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
